// File: rtl/ddr3_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read-address/read-data channel pair between two
// requesters; an in-order tag FIFO steers returning R bursts back to the owning port.
module ddr3_rd_arbiter #(
    parameter int ADDRS       = 27,
    parameter int REQID       = 4,
    parameter int WIDTH       = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s0_arvalid,
    output logic             s0_arready,
    input  logic [ADDRS-1:0] s0_araddr,
    input  logic [REQID-1:0] s0_arid,
    input  logic [7:0]       s0_arlen,
    input  logic [1:0]       s0_arburst,
    output logic             s0_rvalid,
    input  logic             s0_rready,
    output logic             s0_rlast,
    output logic [1:0]       s0_rresp,
    output logic [REQID-1:0] s0_rid,
    output logic [WIDTH-1:0] s0_rdata,
    input  logic             s1_arvalid,
    output logic             s1_arready,
    input  logic [ADDRS-1:0] s1_araddr,
    input  logic [REQID-1:0] s1_arid,
    input  logic [7:0]       s1_arlen,
    input  logic [1:0]       s1_arburst,
    output logic             s1_rvalid,
    input  logic             s1_rready,
    output logic             s1_rlast,
    output logic [1:0]       s1_rresp,
    output logic [REQID-1:0] s1_rid,
    output logic [WIDTH-1:0] s1_rdata,
    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [ADDRS-1:0] m_araddr,
    output logic [REQID-1:0] m_arid,
    output logic [7:0]       m_arlen,
    output logic [1:0]       m_arburst,
    input  logic             m_rvalid,
    output logic             m_rready,
    input  logic             m_rlast,
    input  logic [1:0]       m_rresp,
    input  logic [REQID-1:0] m_rid,
    input  logic [WIDTH-1:0] m_rdata,
    output logic             error_o
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTSTANDING);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t      state;
    logic        last_grant;
    logic        tag_mem [OUTSTANDING];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [PW:0] count;
    logic        can_accept;
    logic        grant;
    logic        push;
    logic        pop;
    logic        head;
    logic        nonempty;

    always_comb begin
        count      = wr_ptr - rd_ptr;
        nonempty   = (count != '0);
        head       = tag_mem[rd_ptr[PW-1:0]];
        // count comes from registered pointers, so a same-cycle pop never frees a slot early
        can_accept = !reset && (state == IDLE) && (count < FULL_CNT);
        grant      = (s0_arvalid && s1_arvalid) ? ~last_grant : s1_arvalid;
        s0_arready = can_accept && s0_arvalid && !grant;
        s1_arready = can_accept && s1_arvalid && grant;
        push       = s0_arready || s1_arready;
        s0_rvalid  = m_rvalid && nonempty && !head;
        s1_rvalid  = m_rvalid && nonempty && head;
        m_rready   = nonempty && (head ? s1_rready : s0_rready);
        pop        = m_rvalid && m_rready && m_rlast;
    end

    assign s0_rlast = m_rlast;
    assign s0_rresp = m_rresp;
    assign s0_rid   = m_rid;
    assign s0_rdata = m_rdata;
    assign s1_rlast = m_rlast;
    assign s1_rresp = m_rresp;
    assign s1_rid   = m_rid;
    assign s1_rdata = m_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            m_arvalid  <= 1'b0;
            last_grant <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            error_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        m_arvalid  <= 1'b1;
                        last_grant <= grant;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (m_rvalid && !nonempty)
                error_o <= 1'b1;
        end
    end

    // Request payload and tag storage carry no reset; push is already blocked during reset.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr[PW-1:0]] <= grant;
            m_araddr  <= grant ? s1_araddr  : s0_araddr;
            m_arid    <= grant ? s1_arid    : s0_arid;
            m_arlen   <= grant ? s1_arlen   : s0_arlen;
            m_arburst <= grant ? s1_arburst : s0_arburst;
        end
    end
endmodule
